// File: rtl/transport_timer_ctrl.sv
// transport_timer_ctrl: playback transport for the audio player.
// Debounces pause/next/prev keys, runs the PAUSED/PLAYING machine, selects the
// current track, counts elapsed play time as MM:SS and drives four 7-seg digits.
// Optional feature: define REPEAT_ALL_EN so that track_end on the last track
// wraps to track 0 and keeps playing; without it the wrap drops back to PAUSED.
module transport_timer_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int NUM_TRACKS   = 8,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int PREV_RESTART = 3,
  parameter bit SEG_ACT_LOW  = 1'b1,
  localparam int TW = $clog2(NUM_TRACKS)
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          pausa_sw,
  input  logic          siguiente_sw,
  input  logic          anterior_sw,
  input  logic          track_end,
  output logic [TW-1:0] track_idx,
  output logic          playing,
  output logic          restart,
  output logic [6:0]    seg1_export,
  output logic [6:0]    seg2_export,
  output logic [6:0]    min1_export,
  output logic [6:0]    min2_export
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(NUM_TRACKS - 1);
  localparam int K_NEXT  = 0;
  localparam int K_PREV  = 1;
  localparam int K_PAUSE = 2;

  typedef enum logic {PAUSED = 1'b0, PLAYING = 1'b1} state_t;

  // Time is held as four BCD digits {m2, m1, s2, s1}; 99:59 is the ceiling.
  function automatic logic [15:0] time_inc(input logic [15:0] t);
    logic [15:0] n;
    n = t;
    if (t != 16'h9959) begin
      if (t[3:0] != 4'd9) n[3:0] = t[3:0] + 4'd1;
      else begin
        n[3:0] = 4'd0;
        if (t[7:4] != 4'd5) n[7:4] = t[7:4] + 4'd1;
        else begin
          n[7:4] = 4'd0;
          if (t[11:8] != 4'd9) n[11:8] = t[11:8] + 4'd1;
          else begin
            n[11:8]  = 4'd0;
            n[15:12] = t[15:12] + 4'd1;
          end
        end
      end
    end
    return n;
  endfunction

  // Segment pattern, bit0 = a .. bit6 = g, polarity per SEG_ACT_LOW.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_ACT_LOW ? ~p : p;
  endfunction

  logic [2:0]    keys_raw;
  logic [2:0]    sync1_q, sync2_q, deb_q, evt_q;
  logic [DW-1:0] db_cnt_q [3];

  assign keys_raw = {pausa_sw, anterior_sw, siguiente_sw};

  // Key synchronisers and debouncers; a 1-cycle event marks each accepted press.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      evt_q   <= '0;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        evt_q[k] <= 1'b0;
        if (sync2_q[k] != deb_q[k]) begin
          if (db_cnt_q[k] == DW'(DEBOUNCE_CYC - 1)) begin
            deb_q[k]    <= sync2_q[k];
            db_cnt_q[k] <= '0;
            evt_q[k]    <= sync2_q[k];
          end else begin
            db_cnt_q[k] <= db_cnt_q[k] + DW'(1);
          end
        end else begin
          db_cnt_q[k] <= '0;
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [TW-1:0] idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tm_q, tm_d;
  logic          restart_q, restart_d;
  logic          tick, clear, past_restart;

  assign tick = (state_q == PLAYING) && (presc_q == PW'(CLK_HZ - 1));
  assign past_restart = (int'(tm_q[15:12]) * 600 + int'(tm_q[11:8]) * 60 +
                         int'(tm_q[7:4]) * 10 + int'(tm_q[3:0])) >= PREV_RESTART;

  // Next-state: key/track_end priority, track selection and the play timer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    tm_d      = tm_q;
    restart_d = 1'b0;
    clear     = 1'b0;
    if (evt_q[K_NEXT]) begin
      idx_d = (idx_q == LAST) ? TW'(0) : idx_q + TW'(1);
      clear = 1'b1;
    end else if (evt_q[K_PREV]) begin
      if (!past_restart) idx_d = (idx_q == TW'(0)) ? LAST : idx_q - TW'(1);
      clear = 1'b1;
    end else if (track_end && (state_q == PLAYING)) begin
      if (idx_q == LAST) begin
        idx_d = TW'(0);
`ifdef REPEAT_ALL_EN
        state_d = PLAYING;
`else
        state_d = PAUSED;
`endif
      end else begin
        idx_d = idx_q + TW'(1);
      end
      clear = 1'b1;
    end else begin
      if (evt_q[K_PAUSE]) state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
      if (state_q == PLAYING) begin
        if (tick) begin
          presc_d = '0;
          tm_d    = time_inc(tm_q);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
    if (clear) begin
      presc_d   = '0;
      tm_d      = '0;
      restart_d = 1'b1;
    end
  end

  // Transport state, track index, prescaler and elapsed time registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= PAUSED;
      idx_q     <= '0;
      presc_q   <= '0;
      tm_q      <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      tm_q      <= tm_d;
      restart_q <= restart_d;
    end
  end

  logic [6:0] seg1_q, seg2_q, min1_q, min2_q;

  // Registered 7-seg decode of the current time digits.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      seg1_q <= seg7(4'd0);
      seg2_q <= seg7(4'd0);
      min1_q <= seg7(4'd0);
      min2_q <= seg7(4'd0);
    end else begin
      seg1_q <= seg7(tm_q[3:0]);
      seg2_q <= seg7(tm_q[7:4]);
      min1_q <= seg7(tm_q[11:8]);
      min2_q <= seg7(tm_q[15:12]);
    end
  end

  assign track_idx   = idx_q;
  assign playing     = (state_q == PLAYING);
  assign restart     = restart_q;
  assign seg1_export = seg1_q;
  assign seg2_export = seg2_q;
  assign min1_export = min1_q;
  assign min2_export = min2_q;

endmodule

// File: tb/tb_transport_timer_ctrl.sv
// Testbench for transport_timer_ctrl (CLK_HZ=10, DEBOUNCE_CYC=4, NUM_TRACKS=4).
// A second instance with CLK_HZ=1 reaches the 99:59 ceiling quickly.
`timescale 1ns/1ps
module tb_transport_timer_ctrl;
  localparam int CLK  = 10;
  localparam int DEB  = 4;
  localparam int NT   = 4;
  localparam int PREV = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic p_sw = 1'b0, n_sw = 1'b0, a_sw = 1'b0, te = 1'b0;
  logic [1:0] idx;
  logic playing, restart;
  logic [6:0] seg1, seg2, min1, min2;

  logic sat_p = 1'b0;
  logic [1:0] sat_idx;
  logic sat_play, sat_rs;
  logic [6:0] sat_s1, sat_s2, sat_m1, sat_m2;

  int errors = 0, checks = 0, restart_cnt = 0;

  // Reference model: whole-second count, fraction of second, track, play flag.
  int m_idx, m_secs, m_frac, m_disp;
  bit m_play, m_restart;
  logic [15:0] m_h [3];
  bit [2:0] m_lvl, m_ev;

  always #5 clk = ~clk;

  transport_timer_ctrl #(.CLK_HZ(CLK), .NUM_TRACKS(NT), .DEBOUNCE_CYC(DEB),
                         .PREV_RESTART(PREV), .SEG_ACT_LOW(1'b1)) dut (
    .clk_clk(clk), .reset_reset(rst), .pausa_sw(p_sw), .siguiente_sw(n_sw),
    .anterior_sw(a_sw), .track_end(te), .track_idx(idx), .playing(playing),
    .restart(restart), .seg1_export(seg1), .seg2_export(seg2),
    .min1_export(min1), .min2_export(min2));

  transport_timer_ctrl #(.CLK_HZ(1), .NUM_TRACKS(NT), .DEBOUNCE_CYC(2),
                         .PREV_RESTART(PREV), .SEG_ACT_LOW(1'b1)) dut_sat (
    .clk_clk(clk), .reset_reset(rst), .pausa_sw(sat_p), .siguiente_sw(1'b0),
    .anterior_sw(1'b0), .track_end(1'b0), .track_idx(sat_idx), .playing(sat_play),
    .restart(sat_rs), .seg1_export(sat_s1), .seg2_export(sat_s2),
    .min1_export(sat_m1), .min2_export(sat_m2));

  function automatic logic [6:0] enc(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
      5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; default: p = 7'h6F;
    endcase
    return ~p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_secs = 0; m_frac = 0; m_disp = 0; m_play = 0; m_restart = 0;
    for (int k = 0; k < 3; k++) m_h[k] = '0;
    m_lvl = '0; m_ev = '0;
  endtask

  task automatic model_step();
    bit chg, was;
    bit [2:0] raw;
    bit all_new;
    int old_secs;
    old_secs = m_secs;
    chg = 0;
    m_restart = 0;
    if (m_ev[0]) begin
      m_idx = (m_idx + 1) % NT; chg = 1;
    end else if (m_ev[1]) begin
      if (m_secs < PREV) m_idx = (m_idx + NT - 1) % NT;
      chg = 1;
    end else if (te && m_play) begin
      if (m_idx == NT - 1) begin
        m_idx = 0;
`ifdef REPEAT_ALL_EN
        m_play = 1;
`else
        m_play = 0;
`endif
      end else m_idx = m_idx + 1;
      chg = 1;
    end else begin
      was = m_play;
      if (m_ev[2]) m_play = !m_play;
      if (was) begin
        m_frac++;
        if (m_frac == CLK) begin
          m_frac = 0;
          if (m_secs < 5999) m_secs++;
        end
      end
    end
    if (chg) begin m_secs = 0; m_frac = 0; m_restart = 1; end
    m_disp = old_secs;
    // A key level is accepted once DEB consecutive synchronised samples disagree with it.
    raw = {p_sw, a_sw, n_sw};
    for (int k = 0; k < 3; k++) begin
      m_h[k] = {m_h[k][14:0], raw[k]};
      m_ev[k] = 0;
      all_new = 1;
      for (int j = 2; j < DEB + 2; j++) if (m_h[k][j] == m_lvl[k]) all_new = 0;
      if (all_new) begin
        m_lvl[k] = !m_lvl[k];
        m_ev[k] = m_lvl[k];
      end
    end
  endtask

  task automatic cyc();
    int s, mm;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    if (restart === 1'b1) restart_cnt++;
    s = m_disp % 60; mm = m_disp / 60;
    chk("track_idx", 32'(idx), 32'(m_idx));
    chk("playing", 32'(playing), 32'(m_play));
    chk("restart", 32'(restart), 32'(m_restart));
    chk("seg1", 32'(seg1), 32'(enc(s % 10)));
    chk("seg2", 32'(seg2), 32'(enc(s / 10)));
    chk("min1", 32'(min1), 32'(enc(mm % 10)));
    chk("min2", 32'(min2), 32'(enc(mm / 10)));
  endtask

  task automatic press(input int k, input int hold);
    case (k) 0: n_sw = 1; 1: a_sw = 1; default: p_sw = 1; endcase
    repeat (hold) cyc();
    n_sw = 0; a_sw = 0; p_sw = 0;
  endtask

  initial begin
    int r0, f, n;
    logic [6:0] s0;
    model_reset();
    repeat (3) cyc();
    chk("rst_idx", 32'(idx), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_restart", 32'(restart), 0);
    chk("rst_seg1", 32'(seg1), 32'h40);
    rst = 0;

    // Play, then one minute of playing time.
    press(2, 6);
    for (int i = 0; i < 20 && !playing; i++) cyc();
    chk("play_after_debounce", 32'(playing), 1);
    repeat (605) cyc();
    chk("t60_seg1", 32'(seg1), 32'h40);
    chk("t60_seg2", 32'(seg2), 32'h40);
    chk("t60_min1", 32'(min1), 32'h79);
    chk("t60_min2", 32'(min2), 32'h40);

    // Bouncing next key, then a clean hold.
    r0 = restart_cnt;
    repeat (3) begin n_sw = 1; cyc(); n_sw = 0; cyc(); cyc(); end
    repeat (10) cyc();
    chk("glitch_no_event", 32'(restart_cnt - r0), 0);
    press(0, 20);
    repeat (10) cyc();
    chk("next_one_restart", 32'(restart_cnt - r0), 1);
    chk("next_idx1", 32'(idx), 1);
    press(0, 6); repeat (10) cyc();
    press(0, 6); repeat (10) cyc();
    chk("next_idx3", 32'(idx), 3);
    press(0, 6); repeat (10) cyc();
    chk("next_wrap_idx0", 32'(idx), 0);

    // Prev late in track restarts; prev early on track 0 wraps.
    for (int i = 0; i < 200 && m_secs < 5; i++) cyc();
    r0 = restart_cnt;
    press(1, 6); repeat (4) cyc();
    chk("prev_late_idx", 32'(idx), 0);
    chk("prev_late_restart", 32'(restart_cnt - r0), 1);
    chk("prev_late_seg1", 32'(seg1), 32'h40);
    chk("prev_late_seg2", 32'(seg2), 32'h40);
    for (int i = 0; i < 200 && m_secs < 1; i++) cyc();
    press(1, 6); repeat (4) cyc();
    chk("prev_early_wrap", 32'(idx), 3);

    // Pause mid-second, resume, fraction preserved.
    for (int i = 0; i < 20 && m_frac != 0; i++) cyc();
    press(2, 6);
    for (int i = 0; i < 20 && playing; i++) cyc();
    chk("paused", 32'(playing), 0);
    f = m_frac;
    repeat (50) cyc();
    press(2, 6);
    for (int i = 0; i < 20 && !playing; i++) cyc();
    s0 = seg1; n = 0;
    for (int i = 0; i < 40 && seg1 == s0; i++) begin cyc(); n++; end
    chk("resume_tick_cycles", 32'(n), 32'(CLK + 1 - f));

    // track_end on the last track.
    te = 1; cyc(); te = 0;
    repeat (3) cyc();
    chk("te_last_idx", 32'(idx), 0);
`ifdef REPEAT_ALL_EN
    chk("te_last_playing", 32'(playing), 1);
`else
    chk("te_last_playing", 32'(playing), 0);
    press(2, 6);
    for (int i = 0; i < 20 && !playing; i++) cyc();
`endif
    press(0, 6); repeat (10) cyc();
    n_sw = 1;
    for (int i = 0; i < 20 && !m_ev[0]; i++) cyc();
    r0 = restart_cnt;
    te = 1; cyc(); te = 0; n_sw = 0;
    repeat (5) cyc();
    chk("next_beats_te_idx", 32'(idx), 2);
    chk("next_beats_te_restart", 32'(restart_cnt - r0), 1);

    // Reset while a next event is pending.
    n_sw = 1;
    for (int i = 0; i < 20 && !m_ev[0]; i++) cyc();
    rst = 1; model_reset(); #1;
    chk("midrst_idx", 32'(idx), 0);
    chk("midrst_playing", 32'(playing), 0);
    chk("midrst_restart", 32'(restart), 0);
    chk("midrst_min1", 32'(min1), 32'h40);
    repeat (2) cyc();
    n_sw = 0; rst = 0;
    r0 = restart_cnt;
    repeat (10) cyc();
    chk("midrst_no_restart", 32'(restart_cnt - r0), 0);

    // Randomised keys and track_end against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) n_sw = ~n_sw;
      if ($urandom_range(0, 24) == 0) a_sw = ~a_sw;
      if ($urandom_range(0, 24) == 0) p_sw = ~p_sw;
      te = ($urandom_range(0, 29) == 0);
      cyc();
    end
    n_sw = 0; a_sw = 0; p_sw = 0; te = 0;

    // Ceiling at 99:59 on the fast instance.
    sat_p = 1; repeat (4) cyc(); sat_p = 0;
    repeat (6100) cyc();
    chk("sat_seg1", 32'(sat_s1), 32'h10);
    chk("sat_seg2", 32'(sat_s2), 32'h12);
    chk("sat_min1", 32'(sat_m1), 32'h10);
    chk("sat_min2", 32'(sat_m2), 32'h10);
    chk("sat_playing", 32'(sat_play), 1);
    repeat (30) cyc();
    chk("sat_hold_seg1", 32'(sat_s1), 32'h10);
    chk("sat_hold_min2", 32'(sat_m2), 32'h10);
    chk("sat_idx", 32'(sat_idx), 0);
    chk("sat_restart", 32'(sat_rs), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
